memory_stage: RTL

Memory-access pipeline stage of the 5-stage RV32I core. It sits between the EX/MEM boundary and the writeback stage. It issues loads and stores to the data memory over a req/ack handshake, with per-byte enables and variable latency. It stalls upstream while an access is outstanding, aligns and sign/zero-extends load data, and registers everything writeback consumes (the MEM/WB pipeline register).

---
 rtl/memory_stage_pkg.sv | 27 ++
 rtl/memory_stage_load_store_align.sv | 44 ++++
 rtl/memory_stage.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/memory_stage_pkg.sv
// Shared encodings for the M stage: funct3 access sizes, result_src values, FSM states, MEM/WB record.
// Byte-lane logic assumes a 32-bit datapath (DW).
package mem_pkg;
  localparam int DW = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic          valid;
    logic          reg_write;
    logic [1:0]    result_src;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] read_data;
    logic [DW-1:0] pc_plus4;
    logic [4:0]    rd;
  } wb_t;
endpackage

// File: rtl/memory_stage_load_store_align.sv
// Byte-lane steering: store data/enables from funct3+addr, and load extraction with sign/zero extension.
// Purely combinational; no backpressure.
module load_store_align
  import mem_pkg::*;
(
  input  logic [2:0]    funct3,
  input  logic [1:0]    addr_lo,
  input  logic [DW-1:0] st_data,
  input  logic [DW-1:0] rdata,
  output logic [3:0]    st_be,
  output logic [DW-1:0] st_wdata,
  output logic [DW-1:0] ld_data
);
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte  = rdata[{addr_lo, 3'b000} +: 8];
    ld_half  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    st_be    = 4'b1111;
    st_wdata = st_data;
    // Store encodings outside SB/SH fall through as a full word.
    case (funct3)
      F3_B: begin
        st_be    = 4'b0001 << addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_H: begin
        st_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
    ld_data = rdata;
    case (funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'b0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'b0, ld_half};
      F3_W:    ld_data = rdata;
      default: ld_data = rdata;
    endcase
  end
endmodule

// File: rtl/memory_stage.sv
// RV32I memory stage + MEM/WB register; optional MISALIGN_TRAP_EN turns misaligned H/W accesses into a flagged no-op.
// Latency: 1 cycle for non-memory ops, 2+ cycles for loads/stores (issue, then wait for dmem_ack).
// Backpressure: stall_m holds upstream while an access is being issued or awaiting ack.
module memory_stage
  import mem_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_m,
  input  logic               reg_write_m,
  input  logic               mem_write_m,
  input  logic [1:0]         result_src_m,
  input  logic [2:0]         funct3_m,
  input  logic [D_WIDTH-1:0] alu_result_m,
  input  logic [D_WIDTH-1:0] write_data_m,
  input  logic [D_WIDTH-1:0] pc_plus4_m,
  input  logic [4:0]         rd_m,
  output logic               stall_m,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [A_WIDTH-1:0] dmem_addr,
  output logic [D_WIDTH-1:0] dmem_wdata,
  output logic [3:0]         dmem_be,
  input  logic               dmem_ack,
  input  logic [D_WIDTH-1:0] dmem_rdata,
  output logic               valid_w,
  output logic               reg_write_w,
  output logic [1:0]         result_src_w,
  output logic [D_WIDTH-1:0] alu_result_w,
  output logic [D_WIDTH-1:0] read_data_w,
  output logic [D_WIDTH-1:0] pc_plus4_w,
  output logic [4:0]         rd_w
`ifdef MISALIGN_TRAP_EN
  ,
  output logic               misaligned_w
`endif
);
  state_e             state_q, state_d;
  logic               dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [A_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
  logic [D_WIDTH-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]         dmem_be_q, dmem_be_d;
  wb_t                wb_q, wb_d, wb_cap;
  logic               is_mem, mis, issue;
  logic [3:0]         st_be;
  logic [D_WIDTH-1:0] st_wdata, ld_data;

  load_store_align u_align (
    .funct3   (funct3_m),
    .addr_lo  (alu_result_m[1:0]),
    .st_data  (write_data_m),
    .rdata    (dmem_rdata),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_data  (ld_data)
  );

  assign is_mem = valid_m & (mem_write_m | (result_src_m == RES_MEM));

`ifdef MISALIGN_TRAP_EN
  logic acc_byte, acc_half, misaligned_q, misaligned_d;
  always_comb begin
    acc_byte = mem_write_m ? (funct3_m == F3_B) : (funct3_m == F3_B || funct3_m == F3_BU);
    acc_half = mem_write_m ? (funct3_m == F3_H) : (funct3_m == F3_H || funct3_m == F3_HU);
    mis = is_mem & ((acc_half & alu_result_m[0]) |
                    (~acc_half & ~acc_byte & (alu_result_m[1:0] != 2'b00)));
  end
`else
  assign mis = 1'b0;
`endif

  assign issue   = is_mem & ~mis;
  assign stall_m = ((state_q == IDLE) & issue) | ((state_q == BUSY) & ~dmem_ack);

  always_comb begin
    wb_cap            = '0;
    wb_cap.valid      = valid_m;
    wb_cap.reg_write  = reg_write_m & valid_m & ~mis;
    wb_cap.result_src = result_src_m;
    wb_cap.alu_result = alu_result_m;
    wb_cap.pc_plus4   = pc_plus4_m;
    wb_cap.rd         = rd_m;
  end

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_be_d    = dmem_be_q;
    wb_d         = '0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d      = BUSY;
          dmem_req_d   = 1'b1;
          dmem_we_d    = mem_write_m;
          dmem_addr_d  = {alu_result_m[A_WIDTH-1:2], 2'b00};
          dmem_wdata_d = mem_write_m ? st_wdata : '0;
          dmem_be_d    = mem_write_m ? st_be : 4'b1111;
        end else begin
          wb_d = wb_cap;
        end
      end
      BUSY: begin
        // M inputs are frozen by stall_m, so the held instruction is captured on ack.
        if (dmem_ack) begin
          state_d        = IDLE;
          dmem_req_d     = 1'b0;
          dmem_we_d      = 1'b0;
          dmem_be_d      = 4'b0000;
          wb_d           = wb_cap;
          wb_d.read_data = dmem_we_q ? '0 : ld_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_be_q    <= 4'b0000;
      wb_q         <= '0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_be_q    <= dmem_be_d;
      wb_q         <= wb_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign misaligned_d = (state_q == IDLE) & mis;
  always_ff @(posedge clk) begin
    if (!rst_n) misaligned_q <= 1'b0;
    else        misaligned_q <= misaligned_d;
  end
  assign misaligned_w = misaligned_q;
`endif

  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign dmem_be      = dmem_be_q;
  assign valid_w      = wb_q.valid;
  assign reg_write_w  = wb_q.reg_write;
  assign result_src_w = wb_q.result_src;
  assign alu_result_w = wb_q.alu_result;
  assign read_data_w  = wb_q.read_data;
  assign pc_plus4_w   = wb_q.pc_plus4;
  assign rd_w         = wb_q.rd;
endmodule
